// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage handshake and HI/LO bus for the multiply/divide unit
interface muldiv_ctrl_if #(parameter int DW = 32);
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic          hilo_rd;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          busy;
  logic          stall;
  logic          done;
  modport master (output start, op, rs_val, rt_val, hilo_rd, input hi, lo, busy, stall, done);
  modport slave (input start, op, rs_val, rt_val, hilo_rd, output hi, lo, busy, stall, done);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative shift-add multiplier / restoring divider owning HI/LO
module muldiv_ctrl #(parameter int DW = 32) (
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave s
);
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t          r_st;
  logic [DW-1:0]   r_a, r_b;
  logic [2*DW-1:0] r_acc;
  logic [DW:0]     r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_div, r_qs, r_rs, r_bz;
  logic            w_sgn, w_go;
  logic [DW-1:0]   w_ua, w_ub, w_quo, w_rem;
  logic [DW:0]     w_madd, w_sh, w_sub;
  logic [2*DW-1:0] w_prod;
  assign w_sgn  = ~s.op[0];
  assign w_go   = s.start & ~s.op[2];
  assign w_ua   = (w_sgn & s.rs_val[DW-1]) ? -s.rs_val : s.rs_val;
  assign w_ub   = (w_sgn & s.rt_val[DW-1]) ? -s.rt_val : s.rt_val;
  assign w_madd = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_sh   = {r_rem[DW-1:0], r_acc[DW-1]};
  assign w_sub  = w_sh - {1'b0, r_b};
  assign w_prod = r_qs ? -r_acc : r_acc;
  assign w_quo  = r_qs ? -r_acc[DW-1:0] : r_acc[DW-1:0];
  assign w_rem  = DW'(r_rs ? -r_rem : r_rem);
  assign s.stall = s.busy & (s.start | s.hilo_rd);
  // sequencer: accept in IDLE, iterate DW times in CALC, sign-correct and write HI/LO in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= IDLE;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_qs   <= 1'b0;
      r_rs   <= 1'b0;
      r_bz   <= 1'b0;
      s.hi   <= '0;
      s.lo   <= '0;
      s.busy <= 1'b0;
      s.done <= 1'b0;
    end else begin
      s.done <= 1'b0;
      case (r_st)
        IDLE: begin
          if (w_go) begin
            r_a    <= w_ua;
            r_b    <= w_ub;
            r_acc  <= {{DW{1'b0}}, s.op[1] ? w_ua : w_ub};
            r_rem  <= '0;
            r_cnt  <= '0;
            r_div  <= s.op[1];
            r_qs   <= w_sgn & (s.rs_val[DW-1] ^ s.rt_val[DW-1]);
            r_rs   <= w_sgn & s.rs_val[DW-1];
            r_bz   <= s.rt_val == '0;
            s.busy <= 1'b1;
            r_st   <= CALC;
          end else if (s.start && s.op == 3'b100) s.hi <= s.rs_val;
          else if (s.start && s.op == 3'b101) s.lo <= s.rs_val;
        end
        CALC: begin
          if (r_div) begin
            r_rem <= w_sub[DW] ? w_sh : w_sub;
            r_acc <= {r_acc[2*DW-2:0], ~w_sub[DW]};
          end else r_acc <= {w_madd, r_acc[DW-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW-1)) r_st <= FIX;
        end
        FIX: begin
          {s.hi, s.lo} <= r_div ? {w_rem, r_bz ? {DW{1'b1}} : w_quo} : w_prod;
          s.busy <= 1'b0;
          s.done <= 1'b1;
          r_st   <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide unit with its sequencing controller for the EX stage.
- Owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Asserts stall to the pipeline when EX issues a new HI/LO operation or reads HI/LO while a 32-iteration operation is still in flight.
- Sits beside the ALU; the ALU never touches HI/LO.

Parameters:
- DW, 32, operand/HI/LO width; iteration count equals DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX issues a HI/LO operation this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- rs_val  in  DW  operand A: multiplicand/dividend, or MTHI/MTLO data.
- rt_val  in  DW  operand B: multiplier/divisor.
- hilo_rd  in  1  EX executes MFHI/MFLO this cycle.
- hi  out  DW  HI register, direct register output.
- lo  out  DW  LO register, direct register output.
- busy  out  1  mult/div in progress.
- stall  out  1  combinational: busy & (start | hilo_rd).
- done  out  1  one-cycle pulse when a mult/div result lands in HI/LO.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Iteration counter, operand and partial-result registers all cleared.
  - The in-flight operation is discarded; there is no partial HI/LO write.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op MULT/MULTU/DIV/DIVU at edge k:
    - latch |rs_val| and |rt_val| (signed ops) or raw values (unsigned ops);
    - latch result-sign bits: quotient/product sign = a[DW-1]^b[DW-1], remainder sign = a[DW-1], each applied only for signed ops;
    - counter=0, go to CALC.
  - start=1 with op MTHI: hi<=rs_val at edge k; stay IDLE; busy stays 0.
  - start=1 with op MTLO: lo<=rs_val at edge k; stay IDLE; busy stays 0.
  - Reserved op: ignored.
- CALC (edges k+1..k+32, counter 0..DW-1):
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*DW accumulator.
  - Divide: restoring, one quotient bit per cycle; remainder register is DW+1 bits wide.
  - Counter == DW-1 goes to FIX.
- FIX (edge k+33):
  - Two's-complement correction of magnitude results per the latched signs.
  - Writes HI/LO; go to IDLE.
- Outputs and latency:
  - busy=1 from after edge k through edge k+33.
  - New HI/LO values are visible after edge k+33, with done=1 for exactly that one cycle.
  - Total latency is DW+2 = 34 edges.
- Results:
  - Multiply: {hi,lo} = full 2*DW-bit product.
  - Divide: lo = quotient, hi = remainder.
- Division by zero (all signedness): hi=rs_val as latched, lo={DW{1}}; still 34 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Stall rules:
  - start while busy: not accepted, stall=1; EX must hold op/operands stable until stall drops.
  - hilo_rd while busy: stall=1.
  - stall drops in the done cycle, so the held request is accepted or the read sees the new HI/LO.
- start and hilo_rd together while IDLE: no stall; the read sees pre-update HI/LO (MFHI/MFLO then MTHI/MULT ordering).
- done never asserts for MTHI/MTLO.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> busy for 33 cycles; done in cycle k+34; hi=0x00000001, lo=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MTHI rs=0x12345678 -> hi=0x12345678 next cycle, no busy, no done.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> hi=7, lo=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 3*4; hold hilo_rd=1 from cycle k+5 -> stall=1 through k+33, stall=0 in the done cycle with lo=12. Second start at k+10 with op DIVU -> not accepted; it is accepted in the done cycle and completes 34 cycles later.
- Start MULT, assert rst at cycle k+10 (mid-clock, asynchronous) -> hi=lo=0, busy=0, done=0 immediately, and done never pulses. After release, MTLO 0xA5A5A5A5 -> lo=0xA5A5A5A5.
